// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU op codes,
// FSM state encodings and MDU operation selects.
package mdu_sequencer_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_sequencer_if.sv
// MDU bus: start/operands, MTHI/MTLO writes, shared-ALU link, status, HI/LO.
// master = EX stage / ALU side, slave = mdu_sequencer.
interface mdu_sequencer_if #(
  parameter int NB_REG       = 32,
  parameter int NB_ALU_CTRLI = 4
);

  logic                    i_start;
  logic                    i_op;
  logic [NB_REG-1:0]       i_rs;
  logic [NB_REG-1:0]       i_rt;
  logic                    i_wr_hi;
  logic                    i_wr_lo;
  logic [NB_REG-1:0]       i_wr_data;
  logic [NB_REG-1:0]       i_alu_result;
  logic [NB_REG-1:0]       o_alu_a;
  logic [NB_REG-1:0]       o_alu_b;
  logic [NB_ALU_CTRLI-1:0] o_alu_op;
  logic                    o_busy;
  logic                    o_done;
  logic [NB_REG-1:0]       o_hi;
  logic [NB_REG-1:0]       o_lo;

  modport master (
    output i_start, i_op, i_rs, i_rt,
    output i_wr_hi, i_wr_lo, i_wr_data,
    output i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_rs, i_rt,
    input  i_wr_hi, i_wr_lo, i_wr_data,
    input  i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op,
    output o_busy, o_done, o_hi, o_lo
  );

endinterface

// File: rtl/mdu_sequencer_step.sv
// One MULTU/DIVU iteration: ALU operands in, next {HI, LO} out.
// Ports: op, hi, lo, m, alu_result in; alu_a/b/op, hi_nxt, lo_nxt out.
module mdu_sequencer_step
  import mdu_sequencer_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int NB_ALU_CTRLI = 4
) (
  input  logic                    op,
  input  logic [NB_REG-1:0]       hi,
  input  logic [NB_REG-1:0]       lo,
  input  logic [NB_REG-1:0]       m,
  input  logic [NB_REG-1:0]       alu_result,
  output logic [NB_REG-1:0]       alu_a,
  output logic [NB_REG-1:0]       alu_b,
  output logic [NB_ALU_CTRLI-1:0] alu_op,
  output logic [NB_REG-1:0]       hi_nxt,
  output logic [NB_REG-1:0]       lo_nxt
);

  logic [NB_REG-1:0] rem;
  logic              ok;
  logic              carry;

  always_comb begin
    // Shifted partial remainder; the bit shifted out of HI
    // forces the subtract when it is set.
    rem   = {hi[NB_REG-2:0], lo[NB_REG-1]};
    ok    = hi[NB_REG-1] | ~(rem < m);
    // Add wrapped iff the sum is below an operand.
    carry = alu_result < hi;
    if (op == OP_DIVU) begin
      alu_op = ALU_SUB;
      alu_a  = rem;
      alu_b  = m;
      hi_nxt = ok ? alu_result : rem;
      lo_nxt = {lo[NB_REG-2:0], ok};
    end else begin
      alu_op = ALU_ADD;
      alu_a  = hi;
      alu_b  = lo[0] ? m : '0;
      hi_nxt = {carry, alu_result[NB_REG-1:1]};
      lo_nxt = {alu_result[0], lo[NB_REG-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer owning HI/LO, driving the shared ALU.
// Ports: i_clock, i_reset (async, high); bus = mdu_sequencer_if.slave.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int NB_ALU_CTRLI = 4,
  parameter int NB_CNT       = 5
) (
  input  logic         i_clock,
  input  logic         i_reset,
  mdu_sequencer_if.slave bus
);

  logic [1:0]              state;
  logic [NB_REG-1:0]       hi;
  logic [NB_REG-1:0]       lo;
  logic [NB_REG-1:0]       m;
  logic [NB_CNT-1:0]       cnt;
  logic                    op;
  logic [NB_REG-1:0]       step_a;
  logic [NB_REG-1:0]       step_b;
  logic [NB_ALU_CTRLI-1:0] step_op;
  logic [NB_REG-1:0]       hi_nxt;
  logic [NB_REG-1:0]       lo_nxt;
  logic                    run;

  mdu_sequencer_step #(
    .NB_REG       (NB_REG),
    .NB_ALU_CTRLI (NB_ALU_CTRLI)
  ) u_step (
    .op         (op),
    .hi         (hi),
    .lo         (lo),
    .m          (m),
    .alu_result (bus.i_alu_result),
    .alu_a      (step_a),
    .alu_b      (step_b),
    .alu_op     (step_op),
    .hi_nxt     (hi_nxt),
    .lo_nxt     (lo_nxt)
  );

  assign run = (state == ST_RUN);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      cnt   <= '0;
      op    <= OP_MULTU;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            m     <= bus.i_rt;
            op    <= bus.i_op;
            hi    <= '0;
            lo    <= bus.i_rs;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            if (bus.i_wr_hi) hi <= bus.i_wr_data;
            if (bus.i_wr_lo) lo <= bus.i_wr_data;
          end
        end
        ST_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_alu_a  = run ? step_a : '0;
  assign bus.o_alu_b  = run ? step_b : '0;
  assign bus.o_alu_op = run ? step_op : ALU_ADD;
  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_done   = (state == ST_DONE);
  assign bus.o_hi     = hi;
  assign bus.o_lo     = lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural shared ALU.
// Scenario tasks check results, latency, write gating and reset.
module tb_mdu_sequencer;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  mdu_sequencer_if #(.NB_REG(32), .NB_ALU_CTRLI(4)) bus ();

  mdu_sequencer #(
    .NB_REG       (32),
    .NB_ALU_CTRLI (4),
    .NB_CNT       (5)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model.
  always_comb begin
    case (bus.o_alu_op)
      4'b0011: bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      4'b0100: bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      default: bus.i_alu_result = 32'h0;
    endcase
  end

  task automatic start_op(input logic op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    bus.i_op    = op;
    bus.i_rs    = a;
    bus.i_rt    = b;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Called at the negedge after the start edge; cyc counts
  // cycles from the one in which i_start was driven.
  task automatic wait_done(output int cyc,
                           output int run_n,
                           output int add_n);
    cyc   = 1;
    run_n = 0;
    add_n = 0;
    while (!bus.o_done && cyc < 100) begin
      if (bus.o_busy) begin
        run_n++;
        if (bus.o_alu_op == 4'b0011) add_n++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    total++;
    if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin
      $display("FAIL reset_hilo hi=%h lo=%h want 0/0",
               bus.o_hi, bus.o_lo);
    end else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      $display("FAIL reset_status busy=%b done=%b want 0/0",
               bus.o_busy, bus.o_done);
    end else passed++;
    total++;
    if (bus.o_alu_a !== 32'h0 || bus.o_alu_b !== 32'h0 ||
        bus.o_alu_op !== 4'b0011) begin
      $display("FAIL idle_alu a=%h b=%h op=%b want 0/0/0011",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
    end else passed++;
  endtask

  task automatic test_multu_max;
    int cyc, run_n, add_n;
    start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, run_n, add_n);
    total++;
    if (cyc !== 33) begin
      $display("FAIL multu_latency got=%0d want 33", cyc);
    end else passed++;
    total++;
    if (run_n !== 32 || add_n !== 32) begin
      $display("FAIL multu_add_ops run=%0d add=%0d want 32/32",
               run_n, add_n);
    end else passed++;
    total++;
    if (bus.o_hi !== 32'hFFFFFFFE || bus.o_lo !== 32'h1) begin
      $display("FAIL multu_max hi=%h lo=%h want fffffffe/1",
               bus.o_hi, bus.o_lo);
    end else passed++;
    @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      $display("FAIL done_pulse done=%b busy=%b want 0/0",
               bus.o_done, bus.o_busy);
    end else passed++;
    total++;
    if (bus.o_hi !== 32'hFFFFFFFE || bus.o_lo !== 32'h1) begin
      $display("FAIL multu_hold hi=%h lo=%h want fffffffe/1",
               bus.o_hi, bus.o_lo);
    end else passed++;
  endtask

  task automatic test_divu;
    int cyc, run_n, add_n;
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(cyc, run_n, add_n);
    total++;
    if (bus.o_lo !== 32'd14 || bus.o_hi !== 32'd2) begin
      $display("FAIL divu_100_7 lo=%0d hi=%0d want 14/2",
               bus.o_lo, bus.o_hi);
    end else passed++;
    total++;
    if (add_n !== 0 || run_n !== 32) begin
      $display("FAIL divu_sub_ops run=%0d add=%0d want 32/0",
               run_n, add_n);
    end else passed++;
    start_op(1'b1, 32'hFFFFFFFF, 32'h80000001);
    wait_done(cyc, run_n, add_n);
    total++;
    if (bus.o_lo !== 32'h1 || bus.o_hi !== 32'h7FFFFFFE) begin
      $display("FAIL divu_ovf lo=%h hi=%h want 1/7ffffffe",
               bus.o_lo, bus.o_hi);
    end else passed++;
  endtask

  task automatic test_div_zero;
    int cyc, run_n, add_n;
    start_op(1'b1, 32'h12345678, 32'h0);
    wait_done(cyc, run_n, add_n);
    total++;
    if (cyc !== 33) begin
      $display("FAIL div0_latency got=%0d want 33", cyc);
    end else passed++;
    total++;
    if (bus.o_lo !== 32'hFFFFFFFF || bus.o_hi !== 32'h12345678) begin
      $display("FAIL div0 lo=%h hi=%h want ffffffff/12345678",
               bus.o_lo, bus.o_hi);
    end else passed++;
  endtask

  task automatic test_ignore_in_run;
    int cyc, run_n, add_n;
    start_op(1'b0, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_op      = 1'b1;
    bus.i_wr_hi   = 1'b1;
    bus.i_wr_data = 32'hDEAD;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_wr_hi = 1'b0;
    wait_done(cyc, run_n, add_n);
    total++;
    if (cyc !== 22 || add_n !== 21) begin
      $display("FAIL run_ignore_timing cyc=%0d add=%0d want 22/21",
               cyc, add_n);
    end else passed++;
    total++;
    if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'd15) begin
      $display("FAIL run_ignore hi=%h lo=%0d want 0/15",
               bus.o_hi, bus.o_lo);
    end else passed++;
  endtask

  task automatic test_mt_writes;
    int cyc, run_n, add_n;
    @(negedge clk);
    @(negedge clk);
    bus.i_wr_hi   = 1'b1;
    bus.i_wr_lo   = 1'b1;
    bus.i_wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    bus.i_wr_hi = 1'b0;
    bus.i_wr_lo = 1'b0;
    total++;
    if (bus.o_hi !== 32'hA5A5A5A5 || bus.o_lo !== 32'hA5A5A5A5) begin
      $display("FAIL mt_both hi=%h lo=%h want a5a5a5a5 x2",
               bus.o_hi, bus.o_lo);
    end else passed++;
    bus.i_start   = 1'b1;
    bus.i_op      = 1'b0;
    bus.i_rs      = 32'd2;
    bus.i_rt      = 32'd3;
    bus.i_wr_lo   = 1'b1;
    bus.i_wr_data = 32'h1111;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_wr_lo = 1'b0;
    total++;
    if (bus.o_busy !== 1'b1 || bus.o_lo !== 32'd2 ||
        bus.o_hi !== 32'h0) begin
      $display("FAIL start_prio busy=%b hi=%h lo=%h want 1/0/2",
               bus.o_busy, bus.o_hi, bus.o_lo);
    end else passed++;
    wait_done(cyc, run_n, add_n);
    total++;
    if (bus.o_lo !== 32'd6 || bus.o_hi !== 32'h0) begin
      $display("FAIL multu_2_3 hi=%h lo=%0d want 0/6",
               bus.o_hi, bus.o_lo);
    end else passed++;
  endtask

  task automatic test_reset_midrun;
    int cyc, run_n, add_n;
    int seen;
    start_op(1'b1, 32'd100, 32'd7);
    repeat (16) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0 ||
        bus.o_busy !== 1'b0) begin
      $display("FAIL midrun_reset hi=%h lo=%h busy=%b want 0/0/0",
               bus.o_hi, bus.o_lo, bus.o_busy);
    end else passed++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL reset_no_done pulses=%0d want 0", seen);
    end else passed++;
    start_op(1'b0, 32'd6, 32'd7);
    wait_done(cyc, run_n, add_n);
    total++;
    if (bus.o_lo !== 32'd42 || bus.o_hi !== 32'h0 || cyc !== 33) begin
      $display("FAIL post_reset_multu hi=%h lo=%0d cyc=%0d want 0/42/33",
               bus.o_hi, bus.o_lo, cyc);
    end else passed++;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    bus.i_start   = 1'b0;
    bus.i_op      = 1'b0;
    bus.i_rs      = 32'h0;
    bus.i_rt      = 32'h0;
    bus.i_wr_hi   = 1'b0;
    bus.i_wr_lo   = 1'b0;
    bus.i_wr_data = 32'h0;
    test_reset();
    test_multu_max();
    test_divu();
    test_div_zero();
    test_ignore_in_run();
    test_mt_writes();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
